// File: rtl/rr_output_arbiter.sv
// ============================================================
// rr_output_arbiter: wormhole round-robin arbiter for one router output
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module rr_output_arbiter #(
  parameter int                   NUM_PORTS    = 5,
  parameter int                   ADDR_W       = 3,
  parameter logic [ADDR_W-1:0]    PORT_CODE    = ADDR_W'(1),
  parameter logic [NUM_PORTS-1:0] EXCLUDE_MASK = NUM_PORTS'(2),
  parameter int                   TIMEOUT      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]   nexthop_addr_i,
  input  logic [NUM_PORTS-1:0]          valid_i,
  input  logic [NUM_PORTS-1:0]          tail_i,
  input  logic                          out_ready_i,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx_o,
  output logic                          locked_o,
  output logic                          xfer_o,
  output logic                          timeout_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state, state_nx;
  logic [IDX_W-1:0]     ptr, ptr_nx;
  logic [NUM_PORTS-1:0] grant, grant_nx;
  logic [IDX_W-1:0]     gidx, gidx_nx;
  logic [CNT_W-1:0]     stall_cnt, stall_nx;
  logic                 tmo, tmo_nx;

  logic [NUM_PORTS-1:0] req;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic [IDX_W-1:0]     release_ptr;
  logic                 xfer;
  logic                 timeout_hit;
  int                   cand;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    assign req[i] = valid_i[i]
                  & (nexthop_addr_i[i*ADDR_W +: ADDR_W] == PORT_CODE)
                  & ~EXCLUDE_MASK[i];
  end

  // Circular scan starting at ptr; first requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  assign xfer        = (state == ST_LOCKED) & valid_i[gidx] & out_ready_i;
  assign timeout_hit = (TIMEOUT > 0) && (state == ST_LOCKED)
                       && (stall_cnt == CNT_W'(TIMEOUT));
  assign release_ptr = (gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant     <= '0;
      gidx      <= '0;
      stall_cnt <= '0;
      tmo       <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant     <= grant_nx;
      gidx      <= gidx_nx;
      stall_cnt <= stall_nx;
      tmo       <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant;
    gidx_nx  = gidx;
    tmo_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nx = ST_LOCKED;
          grant_nx = NUM_PORTS'(1) << winner;
          gidx_nx  = winner;
        end
      end
      ST_LOCKED: begin
        // A tail transfer beats a coincident timeout.
        if (xfer && tail_i[gidx]) begin
          state_nx = ST_IDLE;
          grant_nx = '0;
          ptr_nx   = release_ptr;
        end else if (timeout_hit) begin
          state_nx = ST_IDLE;
          grant_nx = '0;
          ptr_nx   = release_ptr;
          tmo_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase

    if ((state != ST_LOCKED) || xfer || (state_nx != ST_LOCKED)) begin
      stall_nx = '0;
    end else if (stall_cnt != CNT_W'(TIMEOUT)) begin
      stall_nx = stall_cnt + 1'b1;
    end else begin
      stall_nx = stall_cnt;
    end
  end

  always_comb begin
    grant_o     = grant;
    grant_idx_o = gidx;
    locked_o    = (state == ST_LOCKED);
    xfer_o      = xfer;
    timeout_o   = tmo;
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_output_arbiter.sv
// ============================================================
// tb_rr_output_arbiter: directed scoreboard bench for rr_output_arbiter
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_output_arbiter;

  localparam int NP = 5;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP*AW-1:0] addr = '0;
  logic [NP-1:0]   valid = '0;
  logic [NP-1:0]   tail = '0;
  logic            ready = 1'b0;

  logic [NP-1:0]   grant_o;
  logic [2:0]      grant_idx_o;
  logic            locked_o;
  logic            xfer_o;
  logic            timeout_o;

  rr_output_arbiter #(
    .NUM_PORTS(NP),
    .ADDR_W(AW),
    .PORT_CODE(3'd1),
    .EXCLUDE_MASK(5'b00010),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .nexthop_addr_i(addr),
    .valid_i(valid),
    .tail_i(tail),
    .out_ready_i(ready),
    .grant_o(grant_o),
    .grant_idx_o(grant_idx_o),
    .locked_o(locked_o),
    .xfer_o(xfer_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] grant;
    logic [2:0] idx;
    logic       locked;
    logic       xfer;
    logic       tmo;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic p1_seen = 1'b0;

  task automatic push(input logic [4:0] g, input logic [2:0] i,
                      input logic l, input logic x, input logic t);
    exp_t e;
    e.grant = g; e.idx = i; e.locked = l; e.xfer = x; e.tmo = t;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [4:0] t,
                       input logic r, input logic [2:0] code);
    valid = v;
    tail  = t;
    ready = r;
    addr  = {NP{code}};
  endtask

  task automatic chk(input string name, input logic [4:0] g, input logic [2:0] i,
                     input logic l, input logic x, input logic t);
    #1;
    checks++;
    if (grant_o !== g || grant_idx_o !== i || locked_o !== l ||
        xfer_o !== x || timeout_o !== t) begin
      errors++;
      $display("FAIL %s: got grant=%b idx=%0d locked=%b xfer=%b tmo=%b, expected grant=%b idx=%0d locked=%b xfer=%b tmo=%b",
               name, grant_o, grant_idx_o, locked_o, xfer_o, timeout_o, g, i, l, x, t);
    end
  endtask

  // Monitor: an output event is a lock edge, a transfer or a timeout pulse.
  initial begin
    logic prev_locked;
    int   wait_cyc;
    exp_t e;
    logic [2:0] gi;
    prev_locked = 1'b0;
    wait_cyc    = 0;
    forever begin
      @(negedge clk);
      if (grant_o[1]) p1_seen = 1'b1;
      if ((locked_o != prev_locked) || xfer_o || timeout_o) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event @%0t: grant=%b idx=%0d locked=%b xfer=%b tmo=%b",
                   $time, grant_o, grant_idx_o, locked_o, xfer_o, timeout_o);
        end else begin
          e  = expq.pop_front();
          gi = e.locked ? grant_idx_o : e.idx;
          if (grant_o !== e.grant || gi !== e.idx || locked_o !== e.locked ||
              xfer_o !== e.xfer || timeout_o !== e.tmo) begin
            errors++;
            $display("FAIL event @%0t: got grant=%b idx=%0d locked=%b xfer=%b tmo=%b, expected grant=%b idx=%0d locked=%b xfer=%b tmo=%b",
                     $time, grant_o, grant_idx_o, locked_o, xfer_o, timeout_o,
                     e.grant, e.idx, e.locked, e.xfer, e.tmo);
          end
        end
        wait_cyc = 0;
      end else if (expq.size() != 0) begin
        wait_cyc++;
        if (wait_cyc > 8) begin
          e = expq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_event @%0t: no output event, expected grant=%b locked=%b xfer=%b tmo=%b",
                   $time, e.grant, e.locked, e.xfer, e.tmo);
          wait_cyc = 0;
        end
      end
      prev_locked = locked_o;
    end
  end

  initial begin
    step(); step();
    chk("reset_state", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    drive(5'b11111, 5'b00000, 1'b0, 3'd0);
    step();
    chk("idle_wrong_code", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(5'b00010, 5'b00000, 1'b0, 3'd1);
    step();
    chk("idle_excluded_only", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    // All ports request: port 0 first, port 1 excluded.
    drive(5'b11111, 5'b00000, 1'b0, 3'd1);
    step();
    push(5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(5'b11111, 5'b00001, 1'b1, 3'd1);
    push(5'b00001, 3'd0, 1'b1, 1'b1, 1'b0);
    step();
    drive(5'b00101, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b01100, 5'b00000, 1'b0, 3'd1);
    push(5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk("stall_hold_1", 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk("stall_hold_2", 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
    step();
    drive(5'b01100, 5'b00100, 1'b1, 3'd1);
    push(5'b00100, 3'd2, 1'b1, 1'b1, 1'b0);

    // Wrap: port 4 then port 0.
    step();
    drive(5'b10000, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b10001, 5'b10000, 1'b1, 3'd1);
    push(5'b10000, 3'd4, 1'b1, 1'b1, 1'b0);
    step();
    drive(5'b10001, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b00000, 5'b00000, 1'b1, 3'd1);
    push(5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);

    // Timeout after four accumulated stall cycles.
    repeat (4) step();
    chk("timeout_not_early", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(5'b11111, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    push(5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);

    // Tail transfer coinciding with the timeout condition.
    repeat (4) step();
    drive(5'b11111, 5'b00100, 1'b1, 3'd1);
    push(5'b00100, 3'd2, 1'b1, 1'b1, 1'b0);
    step();
    drive(5'b11111, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    push(5'b01000, 3'd3, 1'b1, 1'b0, 1'b0);

    // Reset while locked on port 3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(5'b11111, 5'b00000, 1'b1, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("after_reset_no_xfer", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    drive(5'b11111, 5'b00000, 1'b0, 3'd1);
    push(5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(5'b00000, 5'b00000, 1'b0, 3'd1);
    push(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    repeat (3) step();

    checks++;
    if (p1_seen) begin
      errors++;
      $display("FAIL port1_never_granted: got grant on port 1, expected none");
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, expected 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_output_arbiter.md
RR_OUTPUT_ARBITER -- requirements
Module: rr_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of router input ports (N,S,W,E,L order = index 0..4), range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 3, width of each next-hop address code.
REQ-003 SHALL have parameter PORT_CODE, default 3'd1, next-hop code that selects this output port.
REQ-004 SHALL have parameter EXCLUDE_MASK, default 5'b00010, NUM_PORTS bits; bit i set = input i never requests this output (no U-turn).
REQ-005 SHALL have parameter TIMEOUT, default 0, stall cycles before a forced lock release; 0 disables.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 nexthop_addr_i  input  NUM_PORTS*ADDR_W  port i code at [i*ADDR_W +: ADDR_W].
REQ-010 valid_i  input  NUM_PORTS  port i presents a flit.
REQ-011 tail_i  input  NUM_PORTS  presented flit of port i is a packet tail.
REQ-012 out_ready_i  input  1  downstream credit available this cycle.
REQ-013 grant_o  output  NUM_PORTS  registered one-hot grant; all-zero when unlocked.
REQ-014 grant_idx_o  output  $clog2(NUM_PORTS)  registered index of granted port.
REQ-015 locked_o  output  1  registered; high while a packet holds the output.
REQ-016 xfer_o  output  1  combinational flit-accept strobe to crossbar.
REQ-017 timeout_o  output  1  registered one-cycle pulse on forced release.

Function
REQ-018 Request r[i] SHALL = valid_i[i] & (addr_i == PORT_CODE) & ~EXCLUDE_MASK[i].
REQ-019 FSM SHALL have two states: IDLE (locked_o=0) and LOCKED (locked_o=1).
REQ-020 IDLE, any r set: winner = first i with r[i] scanning ptr, ptr+1, ... circularly mod NUM_PORTS; next cycle LOCKED with grant_o=1<<winner, grant_idx_o=winner (1-cycle grant latency).
REQ-021 IDLE, no r: SHALL remain IDLE, outputs unchanged at zero.
REQ-022 xfer_o SHALL = locked_o & valid_i[grant_idx_o] & out_ready_i; never high in IDLE.
REQ-023 LOCKED: requests from non-granted ports and grant-port address changes SHALL be ignored (wormhole lock).
REQ-024 LOCKED, xfer_o & tail_i[grant_idx_o]: next cycle IDLE, grant_o=0, ptr=(grant_idx_o+1) mod NUM_PORTS; no re-arbitration in the release cycle (one idle bubble minimum).
REQ-025 Single-flit packet (head=tail) SHALL be granted and released by REQ-020/REQ-024 identically.
REQ-026 Pointer wrap: release of index NUM_PORTS-1 SHALL set ptr=0.
REQ-027 Stall counter SHALL count LOCKED cycles with xfer_o=0, clear on any xfer_o or leaving LOCKED, saturate at TIMEOUT.
REQ-028 TIMEOUT>0 and counter reaching TIMEOUT: next cycle IDLE, grant_o=0, ptr advanced as REQ-024, timeout_o=1 for exactly one cycle.
REQ-029 Simultaneous xfer_o with tail and timeout condition: xfer SHALL win; normal release, timeout_o=0.
REQ-030 ptr SHALL change only on release (tail or timeout), never on grant.

Reset
REQ-031 reset=1 at a clock edge SHALL set state IDLE, ptr=0, stall counter=0, grant_o=0, grant_idx_o=0, locked_o=0, timeout_o=0, regardless of state.
REQ-032 Reset mid-packet SHALL drop the lock with no release pointer update; xfer_o=0 in the cycle after reset.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-034 Defaults; reset; all valid_i=1, all addr=1, tail=0 -> one cycle later grant_o=00001, grant_idx_o=0; port 1 never granted.
REQ-035 Port 0 locked, out_ready_i=1, tail_i[0]=1 -> xfer_o=1, next cycle grant_o=0; ports 0,2 requesting -> following cycle grant_o=00100.
REQ-036 Wrap: port 4 granted and released, ports 0 and 4 requesting -> grant_o=00001.
REQ-037 Locked on port 2, out_ready_i=0 for 3 cycles while port 3 requests -> xfer_o=0, grant_o=00100 held; out_ready_i=1 with tail -> release.
REQ-038 TIMEOUT=4; port 0 granted then valid_i[0]=0 -> timeout_o=1 after 4 stalled cycles, locked_o=0, next winner search starts at port 2 (port 1 excluded).
REQ-039 Reset asserted while LOCKED on port 3 -> next cycle grant_o=0, locked_o=0; next grant with all ports requesting = port 0.
